// File: rtl/pe_pkg.sv
// Shared definitions for the pe_my sequencer: FSM encoding, FP32 constants and
// the default RAM address width.
package pe_pkg;

  localparam int unsigned L_RAM_SIZE_DEF = 6;
  localparam int unsigned TIMEOUT_DEF    = 64;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClear,
    StRd,
    StMac,
    StWait,
    StDone
  } pe_state_e;

endpackage

// File: rtl/pe_ctrl.sv
// Sequencer for one pe_my element: streams a B-vector into PE RAM, then issues one MAC
// per element, waiting for each FP result because the PE accumulator feeds back.
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned L_RAM_SIZE = L_RAM_SIZE_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  load_en,
  input  logic [L_RAM_SIZE:0]   len,
  input  logic [31:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [L_RAM_SIZE-1:0] gb_addr,
  input  logic [31:0]           gb_rdata,
  output logic                  pe_aresetn,
  output logic [31:0]           pe_ain,
  output logic [31:0]           pe_din,
  output logic [L_RAM_SIZE-1:0] pe_addr,
  output logic                  pe_we,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [31:0]           pe_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           result
);

  localparam int unsigned LEN_W  = L_RAM_SIZE + 1;
  localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  pe_state_e             r_state, w_state_nxt;
  logic [L_RAM_SIZE-1:0] r_cnt, w_cnt_nxt;
  logic [WDOG_W-1:0]     r_wdog, w_wdog_nxt;
  logic [LEN_W-1:0]      r_len, w_len_nxt;
  logic [31:0]           r_result, w_result_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_last;
  logic                  w_wdog_exp;

  // Compare at LEN_W bits so len = 2**L_RAM_SIZE terminates on cnt = all-ones.
  assign w_last     = ({1'b0, r_cnt} == (r_len - LEN_W'(1)));
  assign w_wdog_exp = (r_wdog == WDOG_W'(TIMEOUT - 1));

  assign pe_aresetn = aresetn & (r_state != StClear);
  assign result     = r_result;
  assign err        = r_err;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_wdog   <= '0;
      r_len    <= '0;
      r_result <= FP_ZERO;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wdog   <= w_wdog_nxt;
      r_len    <= w_len_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_wdog_nxt   = r_wdog;
    w_len_nxt    = r_len;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    s_tready     = 1'b0;
    gb_addr      = '0;
    pe_ain       = FP_ZERO;
    pe_din       = FP_ZERO;
    pe_addr      = '0;
    pe_we        = 1'b0;
    pe_valid     = 1'b0;
    busy         = (r_state != StIdle);
    done         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_len_nxt = len;
          w_err_nxt = 1'b0;
          w_cnt_nxt = '0;
          if (len == '0) begin
            w_result_nxt = FP_ZERO;
            w_state_nxt  = StDone;
          end else if (load_en) begin
            w_state_nxt = StLoad;
          end else begin
            w_state_nxt = StClear;
          end
        end
      end

      StLoad: begin
        s_tready = 1'b1;
        pe_addr  = r_cnt;
        pe_din   = s_tdata;
        pe_we    = s_tvalid;
        if (s_tvalid) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = StClear;
          end else begin
            w_cnt_nxt = r_cnt + L_RAM_SIZE'(1);
          end
        end
      end

      StClear: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StRd;
      end

      StRd: begin
        pe_addr     = r_cnt;
        gb_addr     = r_cnt;
        w_state_nxt = StMac;
      end

      // gb_rdata and the PE's registered RAM read both reflect the address set in StRd.
      StMac: begin
        pe_addr     = r_cnt;
        gb_addr     = r_cnt;
        pe_valid    = 1'b1;
        pe_ain      = gb_rdata;
        w_wdog_nxt  = '0;
        w_state_nxt = StWait;
      end

      StWait: begin
        pe_addr    = r_cnt;
        gb_addr    = r_cnt;
        w_wdog_nxt = r_wdog + WDOG_W'(1);
        if (pe_dvalid) begin
          if (w_last) begin
            w_result_nxt = pe_dout;
            w_state_nxt  = StDone;
          end else begin
            w_cnt_nxt   = r_cnt + L_RAM_SIZE'(1);
            w_state_nxt = StRd;
          end
        end else if (w_wdog_exp) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StDone;
        end
      end

      StDone: begin
        done        = 1'b1;
        w_state_nxt = StIdle;
      end

      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: doc/pe_ctrl.md
Name: pe_ctrl

Overview:
- Sequencer placed directly upstream of one pe_my processing element.
- Loads a B-vector from a valid/ready stream into the PE's local RAM, then runs a dot product. Each step reads one A element from a global buffer and issues one MAC into the PE, then waits for the floating-point result before issuing the next.
- Clears the PE accumulator before each run and registers the final sum for the host.

Parameters:
- L_RAM_SIZE, 6, address width of the PE RAM and global buffer; maximum vector length is 2**L_RAM_SIZE.
- TIMEOUT, 64, maximum cycles spent in WAIT for pe_dvalid before the run aborts with err.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  run request pulse; sampled only in IDLE
- load_en  in  1  sampled with start; 1 = load the B-vector first, 0 = reuse the RAM contents
- len  in  L_RAM_SIZE+1  vector length, 0..2**L_RAM_SIZE; sampled with start
- s_tdata  in  32  B-vector stream data
- s_tvalid  in  1  B-vector stream valid
- s_tready  out  1  B-vector stream ready
- gb_addr  out  L_RAM_SIZE  global-buffer A read address; the buffer has 1-cycle read latency
- gb_rdata  in  32  global-buffer read data
- pe_aresetn  out  1  PE reset, active-low, synchronous at the PE
- pe_ain  out  32  PE port A operand
- pe_din  out  32  PE RAM write data
- pe_addr  out  L_RAM_SIZE  PE RAM address
- pe_we  out  1  PE RAM write enable
- pe_valid  out  1  PE operand valid
- pe_dvalid  in  1  PE result valid
- pe_dout  in  32  PE result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes
- err  out  1  timeout flag; valid while done=1 and held until the next start
- result  out  32  final sum; held until the next run reaches DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cnt=0, wdog=0, result=0, err=0.
  - All outputs are 0 except pe_aresetn, which is 0 while aresetn=0.
  - Reset mid-run abandons the run with no done pulse.
- pe_aresetn = aresetn AND NOT (state==CLEAR).
- pe_ain = gb_rdata when state==MAC, else 0.
- IDLE: on start, latch len and load_en, clear err. Next state by priority:
  - len==0 → DONE with result=0 and no PE activity.
  - load_en=1 → LOAD.
  - otherwise → CLEAR.
  - start while busy is ignored.
- LOAD: s_tready=1. On each s_tvalid&s_tready:
  - drive pe_we=1, pe_addr=cnt, pe_din=s_tdata;
  - if cnt==len-1, go to CLEAR with cnt=0; otherwise increment cnt.
  - With s_tvalid=0 the block stays in LOAD with pe_we=0.
- CLEAR: one cycle with pe_aresetn=0, which zeroes the PE accumulator feedback register. Set cnt=0 → RD.
- RD: pe_addr=cnt, gb_addr=cnt, pe_we=0 → MAC.
- MAC: pe_valid=1 for exactly one cycle. pe_ain=gb_rdata, aligned with the PE's registered RAM read of the same address. → WAIT with wdog=0.
- WAIT: pe_valid=0; wdog increments each cycle.
  - On pe_dvalid: if cnt==len-1, latch result=pe_dout → DONE; otherwise cnt+1 → RD.
  - If wdog reaches TIMEOUT-1 with no pe_dvalid: err=1 and result is left unchanged → DONE.
  - pe_dvalid and timeout in the same cycle: pe_dvalid wins.
- pe_addr and gb_addr hold cnt throughout RD, MAC and WAIT.
- DONE: done=1 for one cycle → IDLE.
- Throughput: exactly one operand is outstanding in the PE at any time, as the accumulator feedback requires.
- Per-element cost: 2 cycles (RD, MAC) plus the PE latency.
- pe_dvalid outside WAIT is ignored.
- len=2**L_RAM_SIZE: cnt wraps only at the terminal compare, never past len-1.

Decomposition:
- Shared package pe_pkg:
  - state encoding (IDLE, LOAD, CLEAR, RD, MAC, WAIT, DONE);
  - FP32 constants FP_ZERO=0x00000000 and FP_ONE=0x3F800000;
  - the default L_RAM_SIZE.
- No sub-module. A single FSM with counters (cnt, wdog) is sufficient.

Test Plan:
Bench: pe_my with a behavioural FP multiply-add model of latency 5, plus a global-buffer model with 1-cycle read latency.
- load_en=1, len=4, stream 2.0 (0x40000000) x4, A=1.0 x4 → done after LOAD plus 4 MAC iterations, result=0x41000000 (8.0), err=0.
- Second start with load_en=0, len=4, A=3.0 (0x40400000) → result=0x41C00000 (24.0). This checks that CLEAR zeroed the previous sum and the RAM contents were reused.
- len=0 → done exactly 2 cycles after start, result=0, pe_valid never asserted, s_tready never asserted.
- Stream s_tvalid toggling 1,0,0,1,... during LOAD → pe_we is asserted only on handshakes and addresses are written 0..len-1 in order.
- PE model suppressed for the third element, len=4 → err=1 and done after TIMEOUT cycles in WAIT; result keeps its previous value.
- aresetn driven low during WAIT → outputs zero immediately; a new start then runs normally to the correct result.
